// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller.
// Drives the A operand of a magnitude comparator and narrows [lo, hi] from the
// Gt/Lt/Eq verdicts until the hidden B operand is hit or the range collapses.
module sar_search_ctrl #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       Gt,
    input  logic                       Lt,
    input  logic                       Eq,
    output logic [WIDTH-1:0]           Guess,
    output logic [WIDTH-1:0]           Result,
    output logic                       Found,
    output logic                       Err,
    output logic                       Busy,
    output logic                       Done,
    output logic [$clog2(WIDTH+2)-1:0] Steps
);
    localparam int SW = $clog2(WIDTH+2);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRIVE  = 2'd1;
    localparam logic [1:0] S_EVAL   = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [CW-1:0]    settle_cnt;
    logic [2:0]       flags;

    // Midpoint of [l, h]; the span is taken one bit wider so the difference
    // never wraps, and hi >= lo always holds so the result fits WIDTH bits.
    function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH-1:0] l,
                                                  input logic [WIDTH-1:0] h);
        logic [WIDTH:0] span;
        span = {1'b0, h} - {1'b0, l};
        return WIDTH'({1'b0, l} + (span >> 1));
    endfunction

    // Comparator verdict packed as {Gt, Lt, Eq}; anything not one-hot is illegal.
    always_comb begin
        flags = {Gt, Lt, Eq};
    end

    // Status outputs decode directly from the state register.
    always_comb begin
        Busy = (state == S_DRIVE) || (state == S_EVAL);
        Done = (state == S_FINISH);
    end

    // Search sequencer: range narrowing, guess update and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            Guess      <= '0;
            Result     <= '0;
            Steps      <= '0;
            lo         <= '0;
            hi         <= '1;
            Found      <= 1'b0;
            Err        <= 1'b0;
            settle_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        lo         <= '0;
                        hi         <= '1;
                        Steps      <= '0;
                        Found      <= 1'b0;
                        Err        <= 1'b0;
                        Guess      <= midpoint('0, '1);
                        settle_cnt <= '0;
                        state      <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (settle_cnt == CW'(SETTLE - 1)) begin
                        state <= S_EVAL;
                    end else begin
                        settle_cnt <= settle_cnt + CW'(1);
                    end
                end
                S_EVAL: begin
                    Steps      <= Steps + SW'(1);
                    Result     <= Guess;
                    settle_cnt <= '0;
                    case (flags)
                        3'b001: begin
                            Found <= 1'b1;
                            state <= S_FINISH;
                        end
                        3'b100: begin
                            // Guess==lo means nothing smaller is left to try.
                            if (Guess == lo) begin
                                state <= S_FINISH;
                            end else begin
                                hi    <= Guess - WIDTH'(1);
                                Guess <= midpoint(lo, Guess - WIDTH'(1));
                                state <= S_DRIVE;
                            end
                        end
                        3'b010: begin
                            // Guess==hi means nothing larger is left to try.
                            if (Guess == hi) begin
                                state <= S_FINISH;
                            end else begin
                                lo    <= Guess + WIDTH'(1);
                                Guess <= midpoint(Guess + WIDTH'(1), hi);
                                state <= S_DRIVE;
                            end
                        end
                        default: begin
                            Err   <= 1'b1;
                            Found <= 1'b0;
                            state <= S_FINISH;
                        end
                    endcase
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: behavioural comparator, integer binary-search
// reference model, directed and randomized searches, start masking and reset.
module tb_sar_search_ctrl;
    localparam int WIDTH  = 4;
    localparam int SETTLE = 1;
    localparam int SW     = $clog2(WIDTH+2);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             Gt, Lt, Eq;
    logic [WIDTH-1:0] Guess, Result;
    logic             Found, Err, Busy, Done;
    logic [SW-1:0]    Steps;

    int n_tests = 0;
    int n_fail  = 0;

    // comparator behaviour: 0 normal, 1 always Lt, 2 Gt+Lt, 3 Gt+Eq on a hit
    int tgt  = 0;
    int mode = 0;

    // observations of one search
    int obs_g[$];
    int obs_done_cyc, obs_ndone, obs_nbusy, obs_busy_bad;

    // expectations of one search
    int exp_g[$];
    int exp_found, exp_err, exp_steps, exp_result;

    sar_search_ctrl #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .Gt(Gt), .Lt(Lt), .Eq(Eq),
        .Guess(Guess), .Result(Result), .Found(Found), .Err(Err),
        .Busy(Busy), .Done(Done), .Steps(Steps)
    );

    always #5 clk = ~clk;

    always_comb begin
        Gt = 1'b0; Lt = 1'b0; Eq = 1'b0;
        case (mode)
            1: Lt = 1'b1;
            2: begin Gt = 1'b1; Lt = 1'b1; end
            3: begin
                Gt = int'(Guess) >= tgt;
                Lt = int'(Guess) <  tgt;
                Eq = int'(Guess) == tgt;
            end
            default: begin
                Gt = int'(Guess) > tgt;
                Lt = int'(Guess) < tgt;
                Eq = int'(Guess) == tgt;
            end
        endcase
    end

    // Plain integer binary search over 0..2^WIDTH-1 following the verdict rules.
    function automatic void model(input int t, input int m);
        int lo, hi, g;
        exp_g.delete();
        exp_found = 0; exp_err = 0; exp_steps = 0; exp_result = 0;
        lo = 0; hi = (1 << WIDTH) - 1;
        while (1) begin
            g = (lo + hi) / 2;
            exp_g.push_back(g);
            exp_steps++;
            exp_result = g;
            if (m == 2 || (m == 3 && g == t)) begin exp_err = 1; break; end
            if (m != 1 && g == t) begin exp_found = 1; break; end
            if (m != 1 && g > t) begin
                if (g == lo) break;
                hi = g - 1;
            end else begin
                if (g == hi) break;
                lo = g + 1;
            end
        end
    endfunction

    // Run one search from IDLE; cycle c counts clock periods after the start edge.
    // With poke set, start is held high throughout Busy and FINISH.
    task automatic do_search(input int t, input int m, input bit poke);
        int bi;
        tgt = t; mode = m;
        obs_g.delete();
        obs_done_cyc = -1; obs_ndone = 0; obs_nbusy = 0; obs_busy_bad = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        bi = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (Busy) begin
                if (obs_done_cyc >= 0) obs_busy_bad = 1;
                if (bi % (SETTLE + 1) == 0) obs_g.push_back(int'(Guess));
                bi++;
            end
            if (Done) begin
                obs_ndone++;
                if (obs_done_cyc < 0) obs_done_cyc = c;
                if (Busy) obs_busy_bad = 1;
            end
            if (poke) start = (obs_done_cyc < 0) || (c == obs_done_cyc);
            if (obs_done_cyc >= 0 && c >= obs_done_cyc + 3) break;
        end
        start = 1'b0;
        obs_nbusy = bi;
    endtask

    task automatic test_reset;
        n_tests++;
        if ({Guess, Result, Steps, Found, Err, Busy, Done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got Guess=%0d Result=%0d Steps=%0d Found=%b Err=%b Busy=%b Done=%b, want all 0",
                     Guess, Result, Steps, Found, Err, Busy, Done);
        end
    endtask

    task automatic test_directed;
        int tt[5] = '{7, 15, 0, 9, 5};
        int mm[5] = '{0, 0, 0, 1, 2};
        for (int i = 0; i < 5; i++) begin
            model(tt[i], mm[i]);
            do_search(tt[i], mm[i], 1'b0);
            n_tests++;
            if (obs_done_cyc !== exp_steps * (SETTLE + 1) + 1 || obs_ndone !== 1) begin
                n_fail++;
                $display("FAIL dir%0d_done: got cycle %0d count %0d, want cycle %0d count 1",
                         i, obs_done_cyc, obs_ndone, exp_steps * (SETTLE + 1) + 1);
            end
            n_tests++;
            if (int'(Steps) !== exp_steps || int'(Found) !== exp_found ||
                int'(Err) !== exp_err || int'(Result) !== exp_result) begin
                n_fail++;
                $display("FAIL dir%0d_status: got Steps=%0d Found=%b Err=%b Result=%0d, want %0d %0d %0d %0d",
                         i, Steps, Found, Err, Result, exp_steps, exp_found, exp_err, exp_result);
            end
            n_tests++;
            if (obs_g != exp_g || obs_nbusy !== exp_steps * (SETTLE + 1) || obs_busy_bad) begin
                n_fail++;
                $display("FAIL dir%0d_guesses: got %p (busy %0d, bad %0d), want %p (busy %0d)",
                         i, obs_g, obs_nbusy, obs_busy_bad, exp_g, exp_steps * (SETTLE + 1));
            end
        end
    endtask

    task automatic test_random;
        int t, m, r;
        bit poke;
        for (int i = 0; i < 24; i++) begin
            t = $urandom_range((1 << WIDTH) - 1, 0);
            r = $urandom_range(9, 0);
            m = (r < 6) ? 0 : (r < 8) ? 3 : 1;
            poke = 1'($urandom_range(1, 0));
            model(t, m);
            do_search(t, m, poke);
            n_tests++;
            if (obs_done_cyc !== exp_steps * (SETTLE + 1) + 1 || obs_ndone !== 1 ||
                int'(Steps) !== exp_steps || int'(Found) !== exp_found ||
                int'(Err) !== exp_err || int'(Result) !== exp_result ||
                obs_g != exp_g || obs_busy_bad) begin
                n_fail++;
                $display("FAIL rnd%0d t=%0d m=%0d poke=%0d: got done@%0d x%0d Steps=%0d Found=%b Err=%b Result=%0d g=%p bad=%0d, want done@%0d Steps=%0d Found=%0d Err=%0d Result=%0d g=%p",
                         i, t, m, poke, obs_done_cyc, obs_ndone, Steps, Found, Err, Result, obs_g, obs_busy_bad,
                         exp_steps * (SETTLE + 1) + 1, exp_steps, exp_found, exp_err, exp_result, exp_g);
            end
        end
    endtask

    task automatic test_ignore_start;
        model(15, 0);
        do_search(15, 0, 1'b1);
        n_tests++;
        if (int'(Steps) !== exp_steps || obs_ndone !== 1 || obs_done_cyc !== 11 || obs_busy_bad) begin
            n_fail++;
            $display("FAIL ignore_start: got Steps=%0d Done count %0d at %0d, busy_after=%0d, want Steps=%0d one Done at 11, no restart",
                     Steps, obs_ndone, obs_done_cyc, obs_busy_bad, exp_steps);
        end
    endtask

    task automatic test_back_to_back;
        model(3, 0);
        do_search(3, 0, 1'b0);
        model(12, 0);
        do_search(12, 0, 1'b0);
        n_tests++;
        if (obs_g != exp_g || int'(Steps) !== exp_steps || int'(Result) !== 12 || Found !== 1'b1) begin
            n_fail++;
            $display("FAIL back_to_back: got g=%p Steps=%0d Result=%0d Found=%b, want g=%p Steps=%0d Result=12 Found=1",
                     obs_g, Steps, Result, Found, exp_g, exp_steps);
        end
        n_tests++;
        if (Guess !== 4'd12 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: got Guess=%0d Busy=%b, want 12 0", Guess, Busy);
        end
    endtask

    task automatic test_reset_mid;
        int dn;
        tgt = 15; mode = 0; dn = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= 5; c++) @(negedge clk);
        n_tests++;
        if (Busy !== 1'b1 || Guess !== 4'd13) begin
            n_fail++;
            $display("FAIL mid_precond: got Busy=%b Guess=%0d, want 1 13", Busy, Guess);
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({Guess, Result, Steps, Found, Err, Busy, Done} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got Guess=%0d Result=%0d Steps=%0d Found=%b Err=%b Busy=%b Done=%b, want all 0",
                     Guess, Result, Steps, Found, Err, Busy, Done);
        end
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (Done || Busy) dn++;
        end
        n_tests++;
        if (dn !== 0 || Steps !== '0) begin
            n_fail++;
            $display("FAIL mid_no_done: got %0d Done/Busy cycles Steps=%0d, want 0 0", dn, Steps);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; start = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_reset;
        test_directed;
        test_random;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
